// File: rtl/sobel_frame_ctrl_if.sv
// Slot-issue and result-marking signals between the frame sequencer and the
// pipeline around it. The sequencer is the master.
//
// Handshake: a slot transfers on a rising clock edge where rd_valid && rd_ready.
// While rd_valid=1 and rd_ready=0 the master holds rd_valid and all three
// addresses stable. res_valid has no back-pressure; res_keep/out_row/out_col
// are combinational answers to the res_valid presented in the same cycle.
interface sobel_frame_ctrl_if #(
  parameter int ADDR_WIDTH = 19
) ();
  logic [ADDR_WIDTH-1:0] rd_addr_top;
  logic [ADDR_WIDTH-1:0] rd_addr_mid;
  logic [ADDR_WIDTH-1:0] rd_addr_bot;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  res_valid;
  logic                  res_keep;
  logic [15:0]           out_row;
  logic [15:0]           out_col;

  modport master (
    output rd_addr_top, rd_addr_mid, rd_addr_bot, rd_valid,
    input  rd_ready,
    input  res_valid,
    output res_keep, out_row, out_col
  );

  modport slave (
    input  rd_addr_top, rd_addr_mid, rd_addr_bot, rd_valid,
    output rd_ready,
    output res_valid,
    input  res_keep, out_row, out_col
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the sobel pipeline: issues WIDTH+2 three-row slots per
// row with edge replication, and marks which returning results are real
// output pixels. done pulses once all WIDTH*HEIGHT pixels have been kept.
module sobel_frame_ctrl #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int ADDR_WIDTH = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state,
  sobel_frame_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0]           LAST_SLOT = 16'(WIDTH + 1);
  localparam logic [15:0]           LAST_ROW  = 16'(HEIGHT - 1);
  localparam logic [15:0]           WIDTH_16  = 16'(WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(WIDTH - 1);
  localparam logic [ADDR_WIDTH:0]   TOTAL     = (ADDR_WIDTH + 1)'(WIDTH * HEIGHT);

  state_t state_q, state_d;

  // issue side: current slot, row and running row bases
  logic [15:0]           s_q, r_q;
  logic [ADDR_WIDTH-1:0] base_top_q, base_mid_q, base_bot_q;
  logic [ADDR_WIDTH-1:0] addr_top_q, addr_mid_q, addr_bot_q;

  // result side: slot within the result row, result row, kept pixel count
  logic [15:0]           k_q, res_row_q;
  logic [ADDR_WIDTH:0]   kept_q;

  logic                  start_ok, issue_fire, last_issue, res_active, keep, kept_hit;
  logic [ADDR_WIDTH-1:0] col_next, bot_adv, mid_adv;

  assign start_ok   = (state_q == S_IDLE) && start;
  assign issue_fire = (state_q == S_ISSUE) && bus.rd_ready;
  assign last_issue = issue_fire && (s_q == LAST_SLOT) && (r_q == LAST_ROW);
  assign res_active = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign keep       = bus.res_valid && res_active && (k_q >= 16'd2);
  assign kept_hit   = keep && (kept_q == TOTAL - 1'b1);

  // Column of slot s+1: s for s+1 in 1..WIDTH, clamped to WIDTH-1 for the
  // right replication slot.
  assign col_next = (s_q >= WIDTH_16) ? LAST_COL : ADDR_WIDTH'(s_q);
  assign mid_adv  = base_mid_q + ROW_STEP;
  // Bottom row stops advancing once r+1 would pass the last row.
  assign bot_adv  = ((r_q + 16'd2) <= LAST_ROW) ? (base_bot_q + ROW_STEP) : base_bot_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE is entered on the edge where the last pixel is kept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (kept_hit || (kept_q == TOTAL)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Issue side: load slot 0 of row 0 on start, step on each accepted slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_q        <= '0;
      r_q        <= '0;
      base_top_q <= '0;
      base_mid_q <= '0;
      base_bot_q <= '0;
      addr_top_q <= '0;
      addr_mid_q <= '0;
      addr_bot_q <= '0;
    end else if (start_ok) begin
      s_q        <= '0;
      r_q        <= '0;
      base_top_q <= '0;
      base_mid_q <= '0;
      base_bot_q <= ROW_STEP;
      addr_top_q <= '0;
      addr_mid_q <= '0;
      addr_bot_q <= ROW_STEP;
    end else if (issue_fire) begin
      if (s_q == LAST_SLOT) begin
        s_q        <= '0;
        r_q        <= r_q + 16'd1;
        base_top_q <= base_mid_q;
        base_mid_q <= mid_adv;
        base_bot_q <= bot_adv;
        addr_top_q <= base_mid_q;
        addr_mid_q <= mid_adv;
        addr_bot_q <= bot_adv;
      end else begin
        s_q        <= s_q + 16'd1;
        addr_top_q <= base_top_q + col_next;
        addr_mid_q <= base_mid_q + col_next;
        addr_bot_q <= base_bot_q + col_next;
      end
    end
  end

  // Result side: count every result while the frame is active; the first two
  // of each row only prime the sobel shift registers.
  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      k_q       <= '0;
      res_row_q <= '0;
      kept_q    <= '0;
    end else if (bus.res_valid && res_active) begin
      kept_q <= kept_q + (ADDR_WIDTH + 1)'(keep);
      if (k_q == LAST_SLOT) begin
        k_q       <= '0;
        res_row_q <= res_row_q + 16'd1;
      end else begin
        k_q <= k_q + 16'd1;
      end
    end
  end

  assign bus.rd_addr_top = addr_top_q;
  assign bus.rd_addr_mid = addr_mid_q;
  assign bus.rd_addr_bot = addr_bot_q;
  assign bus.rd_valid    = (state_q == S_ISSUE);
  assign bus.res_keep    = keep;
  assign bus.out_row     = res_row_q;
  assign bus.out_col     = (k_q >= 16'd2) ? (k_q - 16'd2) : 16'd0;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign dbg_state       = state_q;

endmodule
